// File: rtl/gnpu_pkg.sv
// Shared GNPU definitions: activation-buffer state encoding, element-width
// one-hot constants and the beats-per-tile helper.
package gnpu_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY    = 2'd0,
        BUF_FILLING  = 2'd1,
        BUF_FULL     = 2'd2,
        BUF_DRAINING = 2'd3
    } buf_state_e;

    localparam logic [2:0] WIDTH_1B = 3'b001;
    localparam logic [2:0] WIDTH_2B = 3'b010;
    localparam logic [2:0] WIDTH_4B = 3'b100;

    function automatic logic is_legal_width(input logic [2:0] w);
        return (w == WIDTH_1B) || (w == WIDTH_2B) || (w == WIDTH_4B);
    endfunction

    // A tile is SARRAY_H rows of SARRAY_H*4 bytes; narrower elements need more beats.
    function automatic int beats_per_tile(input int sarray_h, input logic [2:0] w);
        case (w)
            WIDTH_1B: return 4 * sarray_h;
            WIDTH_2B: return 2 * sarray_h;
            default:  return sarray_h;
        endcase
    endfunction

endpackage

// File: rtl/a_buf_ctrl_if.sv
// Loader-to-controller beat handshake for the activation-buffer controller.
interface a_buf_ctrl_if #(
    parameter int LOAD_W = 128
);
    logic              ld_valid_i;
    logic              ld_ready_o;
    logic [2:0]        ld_width_i;
    logic [LOAD_W-1:0] ld_data_i;

    modport master (output ld_valid_i, ld_width_i, ld_data_i, input ld_ready_o);
    modport slave  (input ld_valid_i, ld_width_i, ld_data_i, output ld_ready_o);
endinterface

// File: rtl/a_buf_ctrl_slot.sv
// One activation buffer's lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY,
// with a shared beat/row counter and the width latched on the first beat.
module a_buf_ctrl_slot
    import gnpu_pkg::*;
#(
    parameter int SARRAY_H = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic       sa_ready_i,
    input  logic [2:0] ld_width_i,
    output buf_state_e state_o,
    output logic [2:0] width_o,
    output logic       last_beat_o,
    output logic       rd_fire_o,
    output logic       last_row_o,
    output logic       drain_done_o,
    output logic       err_set_o
);
    localparam int CNT_W = $clog2(4 * SARRAY_H + 1);

    buf_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       width_q, width_d;
    logic [2:0]       first_width;
    logic [CNT_W-1:0] first_beats;

    assign first_width = is_legal_width(ld_width_i) ? ld_width_i : WIDTH_4B;
    assign first_beats = CNT_W'(beats_per_tile(SARRAY_H, first_width));
    assign state_o     = state_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            cnt_q   <= '0;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        width_d      = width_q;
        width_o      = (state_q == BUF_EMPTY) ? first_width : width_q;
        last_beat_o  = 1'b0;
        rd_fire_o    = 1'b0;
        last_row_o   = 1'b0;
        drain_done_o = 1'b0;
        err_set_o    = 1'b0;
        case (state_q)
            BUF_EMPTY: if (wr_en) begin
                width_d   = first_width;
                err_set_o = ~is_legal_width(ld_width_i);
                cnt_d     = first_beats - CNT_W'(1);
                if (first_beats == CNT_W'(1)) begin
                    state_d     = BUF_FULL;
                    last_beat_o = 1'b1;
                end else begin
                    state_d = BUF_FILLING;
                end
            end
            BUF_FILLING: if (wr_en) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = BUF_FULL;
                    last_beat_o = 1'b1;
                end
            end
            BUF_FULL: if (rd_en) begin
                state_d = BUF_DRAINING;
                cnt_d   = CNT_W'(SARRAY_H);
            end
            BUF_DRAINING: if (rd_en) begin
                // Count exhausted: the last row went out last cycle, release the buffer now.
                if (cnt_q == '0) begin
                    state_d      = BUF_EMPTY;
                    drain_done_o = 1'b1;
                end else if (sa_ready_i) begin
                    rd_fire_o  = 1'b1;
                    last_row_o = (cnt_q == CNT_W'(1));
                    cnt_d      = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

endmodule

// File: rtl/a_buf_ctrl.sv
// Double-buffered activation-buffer controller: ping-pong fill/drain with registered
// write/read strobes. Define A_BUF_CTRL_PERF_EN to build the saturating perf counters.
module a_buf_ctrl
    import gnpu_pkg::*;
#(
    parameter int SARRAY_H = 4,
    parameter int LOAD_W   = SARRAY_H * 32
) (
    input  logic              clk,
    input  logic              rst_n,
    a_buf_ctrl_if.slave       ld,
    output logic              wr_valid_o,
    output logic              wr_id_o,
    output logic [2:0]        wr_width_o,
    output logic [LOAD_W-1:0] wr_data_o,
    input  logic              sa_ready_i,
    output logic              rd_valid_o,
    output logic              rd_id_o,
    output logic              tile_done_o,
    output logic [1:0]        full_o,
    output logic              err_o,
    output logic [31:0]       perf_ld_stall_o,
    output logic [31:0]       perf_sa_idle_o
);
    buf_state_e slot_state [2];
    logic [2:0] slot_width [2];
    logic [1:0] last_beat, rd_fire, last_row, drain_done, err_set;
    logic       wr_sel, rd_sel, ld_ready, accept;

    // Ready depends on registered state only, so a buffer freed this cycle is not refilled this cycle.
    assign ld_ready    = (slot_state[wr_sel] == BUF_EMPTY) || (slot_state[wr_sel] == BUF_FILLING);
    assign ld.ld_ready_o = ld_ready;
    assign accept      = ld.ld_valid_i & ld_ready;

    for (genvar k = 0; k < 2; k++) begin : g_slot
        a_buf_ctrl_slot #(.SARRAY_H(SARRAY_H)) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .wr_en        (accept && (wr_sel == 1'(k))),
            .rd_en        (rd_sel == 1'(k)),
            .sa_ready_i   (sa_ready_i),
            .ld_width_i   (ld.ld_width_i),
            .state_o      (slot_state[k]),
            .width_o      (slot_width[k]),
            .last_beat_o  (last_beat[k]),
            .rd_fire_o    (rd_fire[k]),
            .last_row_o   (last_row[k]),
            .drain_done_o (drain_done[k]),
            .err_set_o    (err_set[k])
        );
        assign full_o[k] = (slot_state[k] == BUF_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_valid_o  <= 1'b0;
            wr_id_o     <= 1'b0;
            wr_width_o  <= '0;
            wr_data_o   <= '0;
            rd_valid_o  <= 1'b0;
            rd_id_o     <= 1'b0;
            tile_done_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            wr_valid_o <= accept;
            if (accept) begin
                wr_id_o    <= wr_sel;
                wr_width_o <= slot_width[wr_sel];
                wr_data_o  <= ld.ld_data_i;
                if (last_beat[wr_sel]) wr_sel <= ~wr_sel;
            end
            rd_valid_o  <= rd_fire[rd_sel];
            tile_done_o <= rd_fire[rd_sel] & last_row[rd_sel];
            if (rd_fire[rd_sel]) rd_id_o <= rd_sel;
            if (drain_done[rd_sel]) rd_sel <= ~rd_sel;
            if (|err_set) err_o <= 1'b1;
        end
    end

`ifdef A_BUF_CTRL_PERF_EN
    logic [31:0] stall_q, idle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            idle_q  <= '0;
        end else begin
            if (ld.ld_valid_i && !ld_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (sa_ready_i && rd_fire == 2'b00 && idle_q != '1) idle_q <= idle_q + 32'd1;
        end
    end

    assign perf_ld_stall_o = stall_q;
    assign perf_sa_idle_o  = idle_q;
`else
    assign perf_ld_stall_o = '0;
    assign perf_sa_idle_o  = '0;
`endif

endmodule

// File: tb/tb_a_buf_ctrl.sv
// Directed bench for a_buf_ctrl (SARRAY_H=4): fill/drain timing, width latching,
// ping-pong backpressure, paused drains, illegal width and mid-drain reset.
module tb_a_buf_ctrl;
    import gnpu_pkg::*;

    localparam int SARRAY_H = 4;
    localparam int LOAD_W   = SARRAY_H * 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sa_ready_i;
    logic              wr_valid_o, wr_id_o, rd_valid_o, rd_id_o, tile_done_o, err_o;
    logic [2:0]        wr_width_o;
    logic [LOAD_W-1:0] wr_data_o;
    logic [1:0]        full_o;
    logic [31:0]       perf_ld_stall_o, perf_sa_idle_o;

    a_buf_ctrl_if #(.LOAD_W(LOAD_W)) ld_if ();

    a_buf_ctrl #(.SARRAY_H(SARRAY_H), .LOAD_W(LOAD_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ld              (ld_if),
        .wr_valid_o      (wr_valid_o),
        .wr_id_o         (wr_id_o),
        .wr_width_o      (wr_width_o),
        .wr_data_o       (wr_data_o),
        .sa_ready_i      (sa_ready_i),
        .rd_valid_o      (rd_valid_o),
        .rd_id_o         (rd_id_o),
        .tile_done_o     (tile_done_o),
        .full_o          (full_o),
        .err_o           (err_o),
        .perf_ld_stall_o (perf_ld_stall_o),
        .perf_sa_idle_o  (perf_sa_idle_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int          cyc, beats_left, beats_acc;
    int          n_wr, n_wr_id1, n_rd, n_done, first_wr_id, done_cyc, rise_cyc;
    logic [63:0] wr_mask, rd_mask, done_mask;
    logic [2:0]  width_acc;
    logic [1:0]  full_log [64];
    logic [LOAD_W-1:0] data_log [64];
    int          done_ids [$];

    function automatic logic [LOAD_W-1:0] data_of(input int n);
        return {4{24'hDA7A00, 8'(n)}};
    endfunction

    task automatic check(input string tag, input logic [LOAD_W-1:0] got, input logic [LOAD_W-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        cyc = 0; n_wr = 0; n_wr_id1 = 0; n_rd = 0; n_done = 0; first_wr_id = -1;
        wr_mask = '0; rd_mask = '0; done_mask = '0; width_acc = '0;
        done_ids.delete();
        for (int i = 0; i < 64; i++) begin
            full_log[i] = '0;
            data_log[i] = '0;
        end
    endtask

    // One clock: present a beat if any remain, then sample outputs 1 ns after the edge.
    task automatic tick();
        logic acc;
        ld_if.ld_valid_i = (beats_left > 0);
        ld_if.ld_data_i  = data_of(beats_acc);
        acc = ld_if.ld_valid_i & ld_if.ld_ready_o;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            beats_left--;
            beats_acc++;
        end
        if (cyc < 64) begin
            full_log[cyc] = full_o;
            data_log[cyc] = wr_data_o;
            if (wr_valid_o)  wr_mask[cyc]   = 1'b1;
            if (rd_valid_o)  rd_mask[cyc]   = 1'b1;
            if (tile_done_o) done_mask[cyc] = 1'b1;
        end
        if (wr_valid_o) begin
            n_wr++;
            width_acc |= wr_width_o;
            if (wr_id_o) n_wr_id1++;
            if (first_wr_id < 0) first_wr_id = int'(wr_id_o);
        end
        if (rd_valid_o) n_rd++;
        if (tile_done_o) begin
            n_done++;
            done_ids.push_back(int'(rd_id_o));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        sa_ready_i = 1'b0;
        ld_if.ld_valid_i = 1'b0;
        ld_if.ld_width_i = WIDTH_4B;
        ld_if.ld_data_i  = '0;
        beats_left = 0;
        beats_acc  = 0;
        clear_logs();

        // Reset state, during and after reset
        #3 rst_n = 1'b0;
        #1;
        check("rst_ld_ready", ld_if.ld_ready_o, 1'b1);
        check("rst_full", full_o, 2'b00);
        check("rst_err", err_o, 1'b0);
        check("rst_valids", {wr_valid_o, rd_valid_o, tile_done_o}, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst_ld_ready", ld_if.ld_ready_o, 1'b1);
        check("post_rst_perf", {perf_ld_stall_o, perf_sa_idle_o}, 64'd0);

        // 1) 4 B tile, 4 back-to-back beats, array always ready
        clear_logs();
        sa_ready_i = 1'b1;
        ld_if.ld_width_i = WIDTH_4B;
        beats_left = 4;
        beats_acc  = 0;
        for (int i = 0; i < 12; i++) tick();
        check("s1_wr_cycles", wr_mask[15:0], 16'h001E);
        check("s1_wr_id1_count", n_wr_id1, 0);
        check("s1_wr_width", width_acc, WIDTH_4B);
        check("s1_wr_data_last", data_log[4], data_of(3));
        check("s1_full_c3", full_log[3], 2'b00);
        check("s1_full_c4", full_log[4], 2'b01);
        check("s1_full_c5", full_log[5], 2'b00);
        check("s1_rd_cycles", rd_mask[15:0], 16'h03C0);
        check("s1_done_cycle", done_mask[15:0], 16'h0200);
        check("s1_rd_id", (done_ids.size() == 1) ? done_ids[0] : -1, 0);

        // 2) 1 B tile; width switched to 4 B at beat 5 must be ignored
        clear_logs();
        ld_if.ld_width_i = WIDTH_1B;
        beats_left = 16;
        beats_acc  = 0;
        for (int i = 0; i < 30; i++) begin
            if (beats_acc == 5) ld_if.ld_width_i = WIDTH_4B;
            tick();
        end
        check("s2_wr_count", n_wr, 16);
        check("s2_wr_id1_count", n_wr_id1, 16);
        check("s2_wr_width", width_acc, WIDTH_1B);
        check("s2_rd_count", n_rd, 4);
        check("s2_done_id", (done_ids.size() == 1) ? done_ids[0] : -1, 1);

        // 3) Three 4 B tiles with the array stalled, then released
        clear_logs();
        ld_if.ld_width_i = WIDTH_4B;
        sa_ready_i = 1'b0;
        beats_left = 12;
        beats_acc  = 0;
        for (int i = 0; i < 12; i++) tick();
        check("s3_beats_before_stall", beats_acc, 8);
        check("s3_ld_ready_low", ld_if.ld_ready_o, 1'b0);
        check("s3_full_stalled", full_o, 2'b10);
        check("s3_no_rd_stalled", n_rd, 0);
        clear_logs();
        sa_ready_i = 1'b1;
        done_cyc = -1;
        rise_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_cyc < 0 && tile_done_o) done_cyc = cyc;
            if (done_cyc >= 0 && rise_cyc < 0 && ld_if.ld_ready_o) rise_cyc = cyc;
        end
        check("s3_first_done_cycle", done_cyc, 4);
        check("s3_ready_rise_cycle", rise_cyc, 5);
        check("s3_all_beats", beats_acc, 12);
        check("s3_rd_count", n_rd, 12);
        check("s3_done_count", n_done, 3);
        check("s3_order", (done_ids.size() == 3) ? {done_ids[0][1:0], done_ids[1][1:0], done_ids[2][1:0]} : 6'h3F,
              6'b00_01_00);

        // 4) Drain paused on alternate cycles (buffer 1)
        clear_logs();
        sa_ready_i = 1'b0;
        beats_left = 4;
        beats_acc  = 0;
        for (int i = 0; i < 8; i++) tick();
        check("s4_draining_not_full", full_o, 2'b00);
        check("s4_no_rd_yet", n_rd, 0);
        clear_logs();
        for (int k = 0; k < 12; k++) begin
            sa_ready_i = (k % 2 == 0);
            tick();
        end
        check("s4_rd_cycles", rd_mask[11:0], 12'h0AA);
        check("s4_rd_count", n_rd, 4);
        check("s4_done_cycle", done_mask[11:0], 12'h080);
        check("s4_done_id", (done_ids.size() == 1) ? done_ids[0] : -1, 1);

        // 5) Illegal width on a first beat -> treated as 4 B, sticky error
        check("s5_err_clear_before", err_o, 1'b0);
        clear_logs();
        sa_ready_i = 1'b1;
        ld_if.ld_width_i = 3'b011;
        beats_left = 4;
        beats_acc  = 0;
        for (int i = 0; i < 12; i++) tick();
        check("s5_err_set", err_o, 1'b1);
        check("s5_wr_count", n_wr, 4);
        check("s5_wr_width", width_acc, WIDTH_4B);
        check("s5_full_c4", full_log[4], 2'b01);
        check("s5_done_count", n_done, 1);

        // 6) Reset mid-drain after 2 rows of a tile in buffer 1
        clear_logs();
        ld_if.ld_width_i = WIDTH_4B;
        beats_left = 4;
        beats_acc  = 0;
        for (int i = 0; i < 7; i++) tick();
        check("s6_rows_before_reset", n_rd, 2);
        check("s6_err_persists", err_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_full", full_o, 2'b00);
        check("s6_rst_valids", {wr_valid_o, rd_valid_o, tile_done_o}, 3'b000);
        check("s6_rst_err", err_o, 1'b0);
        check("s6_rst_ld_ready", ld_if.ld_ready_o, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 10; i++) tick();
        check("s6_idle_no_wr", n_wr, 0);
        check("s6_idle_no_rd", n_rd, 0);
        check("s6_idle_ld_ready", ld_if.ld_ready_o, 1'b1);
        clear_logs();
        beats_left = 4;
        beats_acc  = 0;
        for (int i = 0; i < 12; i++) tick();
        check("s6_new_tile_wr_id", first_wr_id, 0);
        check("s6_new_tile_wr_count", n_wr, 4);
        check("s6_new_tile_rd_count", n_rd, 4);
        check("s6_new_tile_done", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/a_buf_ctrl.md
A_BUF_CTRL -- requirements
Module: a_buf_ctrl

Interface
- REQ-001 The module SHALL have parameter SARRAY_H, default 4, meaning systolic array height and number of rows/columns of the activation buffer.
- REQ-002 The module SHALL have parameter LOAD_W, default SARRAY_H*32, meaning load beat width in bits.
- REQ-003 The module SHALL have the following ports (name, direction, width, meaning):
  - clk, in, 1: clock.
  - rst_n, in, 1: reset, asynchronous, active-low.
  - ld_valid_i, in, 1: loader beat valid.
  - ld_ready_o, out, 1: controller can accept a beat.
  - ld_width_i, in, 3: one-hot element width; bit0 = 1 B, bit1 = 2 B, bit2 = 4 B.
  - ld_data_i, in, LOAD_W: loader beat data.
  - wr_valid_o, out, 1: activation-buffer write strobe.
  - wr_id_o, out, 1: target buffer of the write.
  - wr_width_o, out, 3: shift mode for the write.
  - wr_data_o, out, LOAD_W: write data.
  - sa_ready_i, in, 1: array can accept a row this cycle.
  - rd_valid_o, out, 1: activation-buffer read (shift-out) strobe.
  - rd_id_o, out, 1: source buffer of the read.
  - tile_done_o, out, 1: one-cycle pulse on the last read of a tile.
  - full_o, out, 2: per-buffer FULL flag.
  - err_o, out, 1: sticky illegal-width flag.
  - perf_ld_stall_o, out, 32: count of cycles with ld_valid_i & ~ld_ready_o.
  - perf_sa_idle_o, out, 32: count of cycles with sa_ready_i and no rd issued.

Function
- REQ-004 The controller SHALL keep a 2-bit state per buffer: EMPTY, FILLING, FULL, DRAINING.
- REQ-005 It SHALL keep a write pointer wr_sel and a read pointer rd_sel, both reset to 0.
- REQ-006 ld_ready_o SHALL equal 1 exactly when state[wr_sel] is EMPTY or FILLING; the signal is combinational from state only.
- REQ-007 A beat SHALL be accepted when ld_valid_i & ld_ready_o. The next cycle SHALL present wr_valid_o=1 with wr_id_o=wr_sel and registered wr_data_o/wr_width_o (1-cycle latency, no combinational path to wr_*).
- REQ-008 The first accepted beat on an EMPTY buffer SHALL latch the width, move the buffer to FILLING, and load a beat counter with SARRAY_H*4/bytes (4*SARRAY_H, 2*SARRAY_H or SARRAY_H).
- REQ-009 Subsequent beats of the same tile SHALL use the latched width; ld_width_i changes mid-tile SHALL be ignored.
- REQ-010 A non-one-hot ld_width_i on a first beat SHALL be treated as 4 B and SHALL set err_o; err_o stays set until reset.
- REQ-011 On acceptance of the last beat the buffer SHALL become FULL in the next cycle and wr_sel SHALL toggle.
- REQ-012 When state[rd_sel] is FULL, the controller SHALL move it to DRAINING and load a row counter with SARRAY_H.
- REQ-013 While DRAINING, each cycle with sa_ready_i=1 SHALL issue rd_valid_o=1 (registered, next cycle) with rd_id_o=rd_sel and decrement the row counter.
- REQ-014 While DRAINING, a cycle with sa_ready_i=0 SHALL pause the drain without losing the count.
- REQ-015 The earliest rd_valid_o for a buffer SHALL occur 2 cycles after its last beat is accepted, so the final write always lands before the first read.
- REQ-016 tile_done_o SHALL pulse with the last rd_valid_o of a tile.
- REQ-017 In the cycle after the last rd_valid_o of a tile, the buffer SHALL return to EMPTY and rd_sel SHALL toggle.
- REQ-018 Filling one buffer and draining the other SHALL proceed concurrently without either stalling the other.
- REQ-019 When both buffers are FULL or DRAINING, ld_ready_o SHALL be 0 until the drained buffer returns to EMPTY.
- REQ-020 A buffer becoming EMPTY and a first beat to that same buffer in the same cycle SHALL NOT occur, because ready is computed from registered state.
- REQ-021 full_o[k] SHALL be 1 iff state[k] is FULL.

Reset
- REQ-022 Asserting rst_n low SHALL asynchronously force:
  - both states to EMPTY;
  - pointers, counters and latched width to 0;
  - err_o, wr_valid_o, rd_valid_o and tile_done_o to 0;
  - performance counters to 0.
- REQ-023 ld_ready_o SHALL read 1 during and after reset.
- REQ-024 A reset mid-fill or mid-drain SHALL abandon the tile; no wr_valid_o or rd_valid_o SHALL be emitted until new beats arrive.

Configuration
- REQ-025 With A_BUF_CTRL_PERF_EN defined, perf_ld_stall_o and perf_sa_idle_o SHALL count as defined in REQ-003 and saturate at 2^32-1.
- REQ-026 Without A_BUF_CTRL_PERF_EN, both ports SHALL exist and be tied to 0, and no counter flops SHALL be generated.

Structure
- REQ-027 The buffer state encoding, the width one-hot constants and the beats-per-tile function SHALL reside in the shared package gnpu_pkg.
- REQ-028 The per-buffer state/counter logic SHALL be one sub-module, a_buf_ctrl_slot, instantiated twice.
- REQ-029 The pointer and performance logic SHALL remain in the top module.

Verification
- REQ-030 The bench SHALL cover these scenarios (SARRAY_H=4):
  - 4 B tile, 4 beats back-to-back, sa_ready_i=1 → wr_valid_o on cycles 1-4 with wr_id_o=0; full_o=01; rd_valid_o on cycles 6-9 with rd_id_o=0; tile_done_o on cycle 9.
  - 1 B tile → exactly 16 wr_valid_o; ld_width_i switched to 4 B at beat 5 → wr_width_o stays 001 throughout.
  - Three tiles streamed with sa_ready_i=0 → ld_ready_o drops after beat 8; sa_ready_i=1 → ld_ready_o rises the cycle after the first tile's done; tiles drain in order 0, 1, 0.
  - sa_ready_i toggled 1,0,1,0 during a drain → exactly 4 rd_valid_o, spaced on ready cycles only.
  - ld_width_i=3'b011 on a first beat → err_o=1, 4 beats per tile; err_o persists until rst_n.
  - rst_n pulsed mid-drain after 2 rows → full_o=00, no further rd_valid_o; next tile starts at wr_id_o=0.
